ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 133 +++++++++++++
 tb/tb_ifetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: sequential PC, 1-cycle BRAM interface, 2-entry (instr, pc) buffer.
// Optional feature: define IFETCH_MISALIGN_CHECK_EN to trap misaligned redirects in HALT.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inflight_pc_q;
  logic        inflight_q;
  logic [31:0] instr_mem_q [2];
  logic [31:0] pc_mem_q    [2];
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;

  logic [31:0] target_pc;
  logic        redirect_ok;
  logic        redirect_bad;
  logic        pop;
  logic        fill;
  logic        fetch_seq;
  logic [2:0]  occupancy;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  assign target_pc      = redirect_pc;
  assign redirect_ok    = redirect_valid && (redirect_pc[1:0] == 2'b00);
  assign redirect_bad   = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_misalign = misalign_q;
`else
  // Low address bits are dropped so a redirect is always word aligned.
  assign target_pc    = redirect_pc & ~32'h0000_0003;
  assign redirect_ok  = redirect_valid;
  assign redirect_bad = 1'b0;
`endif

  assign instr_valid = (count_q != 2'd0);
  assign instr       = instr_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign pop         = instr_valid && instr_ready;
  // The in-flight response is dropped whenever a redirect lands in its arrival cycle.
  assign fill        = inflight_q && !redirect_valid;

  always_comb begin
    occupancy = {1'b0, count_q} + {2'b00, inflight_q};
    fetch_seq = (state_q == StRun) && (occupancy < (3'd2 + {2'b00, pop}));
  end

  always_comb begin
    imem_en   = 1'b0;
    imem_addr = RESET_PC;
    if (resetn) begin
      imem_en   = redirect_ok || (!redirect_valid && fetch_seq);
      imem_addr = redirect_valid ? target_pc : pc_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StBoot;
      pc_q           <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= 32'h0;
      instr_mem_q[0] <= 32'h0;
      instr_mem_q[1] <= 32'h0;
      pc_mem_q[0]    <= 32'h0;
      pc_mem_q[1]    <= 32'h0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_q     <= 1'b0;
`endif
    end else if (redirect_valid) begin
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      inflight_q    <= redirect_ok;
      inflight_pc_q <= target_pc;
      if (redirect_ok) begin
        pc_q    <= target_pc + 32'd4;
        state_q <= StRun;
      end else if (redirect_bad) begin
        state_q <= StHalt;
      end
`ifdef IFETCH_MISALIGN_CHECK_EN
      misalign_q <= redirect_bad;
`endif
    end else begin
      if (state_q == StBoot) begin
        state_q <= StRun;
      end
      inflight_q <= fetch_seq;
      if (fetch_seq) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      if (fill) begin
        instr_mem_q[wr_ptr_q] <= imem_rdata;
        pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({fill, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: two instances (RESET_PC 0 and FFFF_FFF8), each with a BRAM model.
module tb_ifetch_unit;

  logic        clk;
  logic        resetn;

  logic [31:0] imem_addr0, imem_rdata0, redirect_pc0, instr0, instr_pc0;
  logic        imem_en0, redirect_valid0, instr_valid0, instr_ready0;
`ifdef IFETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign0, fetch_misalign1;
`endif

  logic [31:0] imem_addr1, imem_rdata1, instr1, instr_pc1;
  logic        imem_en1, instr_valid1;
  logic        redirect_valid1 = 1'b0;
  logic [31:0] redirect_pc1 = 32'h0;
  logic        instr_ready1 = 1'b1;

  int total = 0;
  int bad   = 0;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk            (clk),
    .resetn         (resetn),
    .imem_addr      (imem_addr0),
    .imem_en        (imem_en0),
    .imem_rdata     (imem_rdata0),
    .redirect_valid (redirect_valid0),
    .redirect_pc    (redirect_pc0),
    .instr_valid    (instr_valid0),
    .instr_ready    (instr_ready0),
    .instr          (instr0),
    .instr_pc       (instr_pc0)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign0)
`endif
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk            (clk),
    .resetn         (resetn),
    .imem_addr      (imem_addr1),
    .imem_en        (imem_en1),
    .imem_rdata     (imem_rdata1),
    .redirect_valid (redirect_valid1),
    .redirect_pc    (redirect_pc1),
    .instr_valid    (instr_valid1),
    .instr_ready    (instr_ready1),
    .instr          (instr1),
    .instr_pc       (instr_pc1)
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign1)
`endif
  );

  // BRAM contents: word[i] = i + 0x100.
  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return {2'b00, addr[31:2]} + 32'h100;
  endfunction

  always @(posedge clk) begin
    if (imem_en0) imem_rdata0 <= word_at(imem_addr0);
    if (imem_en1) imem_rdata1 <= word_at(imem_addr1);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn          = 1'b0;
    instr_ready0    = 1'b1;
    redirect_valid0 = 1'b0;
    redirect_pc0    = 32'h0;
    imem_rdata0     = 32'h0;
    imem_rdata1     = 32'h0;
    #2;
    chk("rst_en", imem_en0, 1'b0);
    chk("rst_valid", instr_valid0, 1'b0);
    chk("rst_addr", imem_addr0, 32'h0);
    chk("rst_instr", instr0, 32'h0);
    chk("rst_pc", instr_pc0, 32'h0);
    chk("rst_addr1", imem_addr1, 32'hFFFF_FFF8);
`ifdef IFETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", fetch_misalign0, 1'b0);
`endif

    // Streaming with decode always ready.
    tick; resetn = 1'b1; #1;
    chk("boot_en", imem_en0, 1'b0);
    tick; #1;
    chk("c1_en", imem_en0, 1'b1);
    chk("c1_addr", imem_addr0, 32'h0);
    chk("c1_addr1", imem_addr1, 32'hFFFF_FFF8);
    tick; #1;
    chk("c2_en", imem_en0, 1'b1);
    chk("c2_addr", imem_addr0, 32'h4);
    chk("c2_valid", instr_valid0, 1'b0);
    tick; #1;
    chk("c3_valid", instr_valid0, 1'b1);
    chk("c3_pc", instr_pc0, 32'h0);
    chk("c3_instr", instr0, 32'h100);
    chk("c3_addr", imem_addr0, 32'h8);
    chk("c3_pc1", instr_pc1, 32'hFFFF_FFF8);
    chk("c3_instr1", instr1, 32'h4000_00FE);
    tick; #1;
    chk("c4_pc", instr_pc0, 32'h4);
    chk("c4_instr", instr0, 32'h101);
    chk("c4_pc1", instr_pc1, 32'hFFFF_FFFC);
    chk("c4_instr1", instr1, 32'h4000_00FF);
    tick; #1;
    chk("c5_pc", instr_pc0, 32'h8);
    chk("c5_instr", instr0, 32'h102);
    chk("c5_en", imem_en0, 1'b1);
    chk("c5_pc1", instr_pc1, 32'h0);
    chk("c5_instr1", instr1, 32'h100);

    // Asynchronous reset in the middle of a fetch.
    #2; resetn = 1'b0; #1;
    chk("mid_rst_en", imem_en0, 1'b0);
    chk("mid_rst_valid", instr_valid0, 1'b0);
    chk("mid_rst_addr", imem_addr0, 32'h0);
    chk("mid_rst_instr", instr0, 32'h0);
    chk("mid_rst_pc", instr_pc0, 32'h0);
    instr_ready0 = 1'b0;

    // Backpressure: decode stalls, buffer fills to two entries.
    tick; resetn = 1'b1; #1;
    chk("bp_boot_en", imem_en0, 1'b0);
    tick; #1;
    chk("bp_c1_addr", imem_addr0, 32'h0);
    chk("bp_c1_en", imem_en0, 1'b1);
    tick; #1;
    chk("bp_c2_addr", imem_addr0, 32'h4);
    chk("bp_c2_en", imem_en0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick; #1;
      chk($sformatf("bp_hold%0d_en", i), imem_en0, 1'b0);
      chk($sformatf("bp_hold%0d_valid", i), instr_valid0, 1'b1);
      chk($sformatf("bp_hold%0d_pc", i), instr_pc0, 32'h0);
      chk($sformatf("bp_hold%0d_instr", i), instr0, 32'h100);
    end
    tick; instr_ready0 = 1'b1; #1;
    chk("rel0_pc", instr_pc0, 32'h0);
    chk("rel0_instr", instr0, 32'h100);
    chk("rel0_addr", imem_addr0, 32'h8);
    tick; #1;
    chk("rel1_valid", instr_valid0, 1'b1);
    chk("rel1_pc", instr_pc0, 32'h4);
    chk("rel1_instr", instr0, 32'h101);
    tick; #1;
    chk("rel2_valid", instr_valid0, 1'b1);
    chk("rel2_pc", instr_pc0, 32'h8);
    chk("rel2_instr", instr0, 32'h102);

    // Redirect with buffered and in-flight words pending.
    tick; instr_ready0 = 1'b0; redirect_valid0 = 1'b1; redirect_pc0 = 32'h400; #1;
    chk("rd_en", imem_en0, 1'b1);
    chk("rd_addr", imem_addr0, 32'h400);
    tick; redirect_valid0 = 1'b0; instr_ready0 = 1'b1; #1;
    chk("rd_next_valid", instr_valid0, 1'b0);
    tick; #1;
    chk("rd_valid", instr_valid0, 1'b1);
    chk("rd_pc", instr_pc0, 32'h400);
    chk("rd_instr", instr0, 32'h200);
    tick; #1;
    chk("rd2_pc", instr_pc0, 32'h404);
    chk("rd2_instr", instr0, 32'h201);

    // Redirect during the boot cycle.
    resetn = 1'b0;
    tick; resetn = 1'b1; redirect_valid0 = 1'b1; redirect_pc0 = 32'h800; #1;
    chk("boot_rd_en", imem_en0, 1'b1);
    chk("boot_rd_addr", imem_addr0, 32'h800);
    tick; redirect_valid0 = 1'b0; #1;
    chk("boot_rd_valid0", instr_valid0, 1'b0);
    chk("boot_rd_addr2", imem_addr0, 32'h804);
    tick; #1;
    chk("boot_rd_pc", instr_pc0, 32'h800);
    chk("boot_rd_instr", instr0, 32'h300);

`ifdef IFETCH_MISALIGN_CHECK_EN
    tick; redirect_valid0 = 1'b1; redirect_pc0 = 32'h402; #1;
    chk("mis_en", imem_en0, 1'b0);
    tick; redirect_valid0 = 1'b0; #1;
    chk("mis_flag", fetch_misalign0, 1'b1);
    chk("mis_en2", imem_en0, 1'b0);
    chk("mis_valid", instr_valid0, 1'b0);
    tick; #1;
    chk("mis_hold_flag", fetch_misalign0, 1'b1);
    chk("mis_hold_en", imem_en0, 1'b0);
    redirect_valid0 = 1'b1; redirect_pc0 = 32'h500; #1;
    chk("mis_rd_en", imem_en0, 1'b1);
    chk("mis_rd_addr", imem_addr0, 32'h500);
    tick; redirect_valid0 = 1'b0; #1;
    chk("mis_clr", fetch_misalign0, 1'b0);
    chk("mis_clr_valid", instr_valid0, 1'b0);
    tick; #1;
    chk("mis_pc", instr_pc0, 32'h500);
    chk("mis_instr", instr0, 32'h240);
`else
    tick; redirect_valid0 = 1'b1; redirect_pc0 = 32'h803; #1;
    chk("lowbits_en", imem_en0, 1'b1);
    chk("lowbits_addr", imem_addr0, 32'h800);
    tick; redirect_valid0 = 1'b0; #1;
    chk("lowbits_valid0", instr_valid0, 1'b0);
    tick; #1;
    chk("lowbits_pc", instr_pc0, 32'h800);
    chk("lowbits_instr", instr0, 32'h300);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
